// File: rtl/tx_fire_con.sv
// tx_fire_con: transmit firing-delay controller with a double-buffered delay table.
// Optional macro TX_CH_MASK_EN adds the ch_mask port, a per-channel fire enable latched on start.
module tx_fire_con #(
   parameter int NUM_CHANNELS = 16,
   parameter int MAX_DELAY    = 256,
   parameter int DELAY_W      = 8,
   parameter int PULSE_LEN    = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            wr_en,
   input  logic [$clog2(NUM_CHANNELS)-1:0] wr_addr,
   input  logic [DELAY_W-1:0]              wr_delay,
   input  logic                            start,
   input  logic                            abort,
`ifdef TX_CH_MASK_EN
   input  logic [NUM_CHANNELS-1:0]         ch_mask,
`endif
   output logic [NUM_CHANNELS-1:0]         pulse_out,
   output logic                            busy,
   output logic                            done
);

   localparam int ADDR_W = $clog2(NUM_CHANNELS);
   // Wide enough for the terminal count plus one, so the delay+pulse window never wraps.
   localparam int CNT_W = $clog2(MAX_DELAY + PULSE_LEN + 2);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_DELAY + PULSE_LEN);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ARM  = 2'd1;
   localparam logic [1:0] FIRE = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]              state;
   logic [CNT_W-1:0]        cnt;
   logic [DELAY_W-1:0]      shadow [NUM_CHANNELS];
   logic [DELAY_W-1:0]      active [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] mask_in;
   logic [NUM_CHANNELS-1:0] mask_active;
   logic [NUM_CHANNELS-1:0] hit;
   logic                    addr_ok;
   logic                    start_ok;

`ifdef TX_CH_MASK_EN
   assign mask_in = ch_mask;
`else
   assign mask_in = '1;
`endif

   generate
      if ((1 << ADDR_W) > NUM_CHANNELS) begin : g_addr_chk
         assign addr_ok = (32'(wr_addr) < NUM_CHANNELS);
      end else begin : g_addr_full
         assign addr_ok = 1'b1;
      end
   endgenerate

   assign start_ok = (state == IDLE) && start;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            shadow[i] <= '0;
         end
      end else if (wr_en && addr_ok) begin
         shadow[wr_addr] <= wr_delay;
      end
   end

   // The active copy samples shadow before any same-cycle write lands, so that write waits for the next shot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            active[i] <= '0;
         end
         mask_active <= '0;
      end else if (start_ok) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            active[i] <= shadow[i];
         end
         mask_active <= mask_in;
      end
   end

   // cnt is 0 in the first FIRE cycle, which only primes the timebase; firing offset zero is cnt==1.
   always_comb begin
      hit = '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         hit[i] = mask_active[i]
                  && (cnt > CNT_W'(active[i]))
                  && (cnt <= CNT_W'(active[i]) + CNT_W'(PULSE_LEN));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         pulse_out <= '0;
      end else begin
         pulse_out <= '0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= ARM;
                  cnt   <= '0;
               end
            end
            ARM: begin
               state <= FIRE;
            end
            FIRE: begin
               if (abort) begin
                  state <= IDLE;
               end else begin
                  pulse_out <= hit;
                  cnt       <= cnt + 1'b1;
                  if (cnt == LAST_CNT) begin
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule
